// File: rtl/seq_pattern_tx_if.sv
// Handshake/data bundle for the serial pattern transmitter.
// Master drives a transfer request; slave returns the serial stream.
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pat_in;
    logic [CNT_W-1:0] rep_in;
    logic [CNT_W-1:0] gap_in;
    logic             bit_out;
    logic             bit_valid;
    logic             frame_sof;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pat_in, rep_in, gap_in,
        input  bit_out, bit_valid, frame_sof, busy, done
    );

    modport slave (
        input  start, abort, pat_in, rep_in, gap_in,
        output bit_out, bit_valid, frame_sof, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first,
// repeated a programmable number of times with optional idle gaps.
module seq_pattern_tx #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    seq_pattern_tx_if.slave   bus
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [PAT_W-1:0] pat_r;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] rep_left;
    logic [CNT_W-1:0] gap_r;
    logic [CNT_W-1:0] gap_cnt;
    logic             last_bit;
    logic             last_rep;
    logic             go;

    assign last_bit = (idx == '0);
    assign last_rep = (rep_left == CNT_W'(1));
    assign go       = bus.start && !bus.abort;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state decode; abort cancels only an active transfer
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (go) state_n = SEND;
            SEND: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (last_bit) begin
                    if (last_rep)          state_n = DONE;
                    else if (gap_r != '0)  state_n = GAP;
                end
            end
            GAP: begin
                if (bus.abort)                     state_n = IDLE;
                else if (gap_cnt == CNT_W'(1))     state_n = SEND;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Latched transfer parameters and bit/repeat/gap counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r    <= '0;
            idx      <= '0;
            rep_left <= '0;
            gap_r    <= '0;
            gap_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        pat_r    <= bus.pat_in;
                        gap_r    <= bus.gap_in;
                        rep_left <= (bus.rep_in == '0) ? CNT_W'(1)
                                                       : bus.rep_in;
                        idx      <= IDX_TOP;
                    end
                end
                SEND: begin
                    if (!bus.abort) begin
                        if (!last_bit) begin
                            idx <= idx - 1'b1;
                        end else if (!last_rep) begin
                            rep_left <= rep_left - 1'b1;
                            idx      <= IDX_TOP;
                            gap_cnt  <= gap_r;
                        end
                    end
                end
                GAP: begin
                    if (!bus.abort) gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        bus.bit_out   = IDLE_BIT;
        bus.bit_valid = 1'b0;
        bus.frame_sof = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        unique case (state)
            SEND: begin
                bus.bit_out   = pat_r[idx];
                bus.bit_valid = 1'b1;
                bus.frame_sof = (idx == IDX_TOP);
                bus.busy      = 1'b1;
            end
            GAP:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx against a frame-level
// reference model of the expected per-cycle output stream.
module tb_seq_pattern_tx;
    localparam int PAT_W = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_pattern_tx #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .IDLE_BIT(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // {bit_out, bit_valid, frame_sof, busy, done}
    logic [4:0] expq[$];
    logic [4:0] gotq[$];

    function automatic logic [4:0] obs();
        return {bus.bit_out, bus.bit_valid, bus.frame_sof,
                bus.busy, bus.done};
    endfunction

    // Expected stream, one entry per cycle after the start edge
    function automatic void build(input logic [PAT_W-1:0] pat,
                                  input int rep, input int gap);
        int r;
        r = (rep == 0) ? 1 : rep;
        expq.delete();
        for (int k = 0; k < r; k++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                expq.push_back({pat[b], 1'b1, (b == PAT_W - 1),
                                1'b1, 1'b0});
            if (k < r - 1)
                for (int g = 0; g < gap; g++)
                    expq.push_back(5'b00010);
        end
        expq.push_back(5'b00001);
        expq.push_back(5'b00000);
    endfunction

    task automatic launch(input logic [PAT_W-1:0] pat,
                          input int rep, input int gap);
        @(negedge clk);
        bus.pat_in = pat;
        bus.rep_in = CNT_W'(rep);
        bus.gap_in = CNT_W'(gap);
        bus.start  = 1'b1;
        build(pat, rep, gap);
    endtask

    task automatic capture(input int n);
        gotq.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            gotq.push_back(obs());
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 5'b00000) begin
                errors++;
                $display("FAIL reset cyc%0d got=%b exp=00000", i, obs());
            end
        end
    endtask

    task automatic test_single();
        launch(4'b1010, 1, 0);
        capture(expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (gotq[i] !== expq[i]) begin
                errors++;
                $display("FAIL single cyc%0d got=%b exp=%b",
                         i, gotq[i], expq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sofs;
        launch(4'b1010, 3, 0);
        capture(expq.size());
        sofs = 0;
        for (int i = 0; i < expq.size(); i++) begin
            sofs += int'(gotq[i][2]);
            checks++;
            if (gotq[i] !== expq[i]) begin
                errors++;
                $display("FAIL b2b cyc%0d got=%b exp=%b",
                         i, gotq[i], expq[i]);
            end
        end
        checks++;
        if (sofs !== 3) begin
            errors++;
            $display("FAIL b2b_sof_count got=%0d exp=3", sofs);
        end
    endtask

    task automatic test_gap();
        launch(4'b1100, 2, 2);
        capture(expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (gotq[i] !== expq[i]) begin
                errors++;
                $display("FAIL gap cyc%0d got=%b exp=%b",
                         i, gotq[i], expq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [PAT_W-1:0] p;
        int r;
        int g;
        for (int n = 0; n < 12; n++) begin
            p = PAT_W'($urandom);
            r = $urandom_range(0, 5);
            g = $urandom_range(0, 3);
            launch(p, r, g);
            capture(expq.size());
            for (int i = 0; i < expq.size(); i++) begin
                checks++;
                if (gotq[i] !== expq[i]) begin
                    errors++;
                    $display("FAIL rand p=%b r=%0d g=%0d cyc%0d got=%b exp=%b",
                             p, r, g, i, gotq[i], expq[i]);
                end
            end
        end
    endtask

    task automatic test_max();
        launch(PAT_W'($urandom), 15, 15);
        capture(expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (gotq[i] !== expq[i]) begin
                errors++;
                $display("FAIL max cyc%0d got=%b exp=%b",
                         i, gotq[i], expq[i]);
            end
        end
    endtask

    // start re-pulsed and inputs changed mid-frame; start held in DONE
    task automatic test_disturb();
        int n;
        launch(4'b1001, 2, 1);
        n = expq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            checks++;
            if (obs() !== expq[i]) begin
                errors++;
                $display("FAIL disturb cyc%0d got=%b exp=%b",
                         i, obs(), expq[i]);
            end
            if (i == 1) begin
                bus.start  = 1'b1;
                bus.pat_in = 4'b0110;
                bus.rep_in = 4'd7;
                bus.gap_in = 4'd0;
            end
            if (i == n - 2) bus.start = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (obs() !== 5'b00000) begin
            errors++;
            $display("FAIL disturb_after got=%b exp=00000", obs());
        end
    endtask

    task automatic test_abort();
        launch(4'b1011, 2, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            checks++;
            if (obs() !== expq[i]) begin
                errors++;
                $display("FAIL abort_pre cyc%0d got=%b exp=%b",
                         i, obs(), expq[i]);
            end
        end
        bus.abort = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.abort = 1'b0;
            checks++;
            if (obs() !== 5'b00000) begin
                errors++;
                $display("FAIL abort_post cyc%0d got=%b exp=00000",
                         i, obs());
            end
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs() !== 5'b00000) begin
                errors++;
                $display("FAIL abort_start cyc%0d got=%b exp=00000",
                         i, obs());
            end
            @(negedge clk);
        end
        launch(4'b0111, 2, 3);
        capture(expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (gotq[i] !== expq[i]) begin
                errors++;
                $display("FAIL abort_restart cyc%0d got=%b exp=%b",
                         i, gotq[i], expq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_gap();
        launch(4'b0110, 3, 4);
        for (int i = 0; i <= PAT_W + 1; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            checks++;
            if (obs() !== expq[i]) begin
                errors++;
                $display("FAIL rstgap_pre cyc%0d got=%b exp=%b",
                         i, obs(), expq[i]);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 5'b00000) begin
            errors++;
            $display("FAIL rstgap_async got=%b exp=00000", obs());
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 5'b00000) begin
            errors++;
            $display("FAIL rstgap_release got=%b exp=00000", obs());
        end
    endtask

    task automatic test_rep_zero();
        int nvalid;
        launch(4'b1101, 0, 3);
        capture(expq.size());
        nvalid = 0;
        for (int i = 0; i < expq.size(); i++) begin
            nvalid += int'(gotq[i][3]);
            checks++;
            if (gotq[i] !== expq[i]) begin
                errors++;
                $display("FAIL rep0 cyc%0d got=%b exp=%b",
                         i, gotq[i], expq[i]);
            end
        end
        checks++;
        if (nvalid !== PAT_W) begin
            errors++;
            $display("FAIL rep0_bits got=%0d exp=%0d", nvalid, PAT_W);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.pat_in = '0;
        bus.rep_in = '0;
        bus.gap_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_disturb();
        test_abort();
        test_random();
        test_max();
        test_reset_mid_gap();
        test_rep_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: loads a PAT_W-bit pattern and emits it MSB-first on a 1-bit stream, one bit per clock.
- Repeats the pattern a programmable number of times, with optional idle gap cycles between repetitions.
- Acts as the stimulus/transmit end for the serial sequence detectors in the FSM block set; `bit_out` drives a detector's serial input `a` directly.

Parameters:
- PAT_W, 4, pattern length in bits (>=2)
- CNT_W, 4, width of the repeat-count and gap-count inputs
- IDLE_BIT, 1'b0, level driven on `bit_out` when no pattern bit is being sent

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request a transfer; sampled only in IDLE
- abort  input  1  synchronous cancel of a transfer in progress
- pat_in  input  PAT_W  pattern; bit PAT_W-1 is sent first
- rep_in  input  CNT_W  number of repetitions; 0 is treated as 1
- gap_in  input  CNT_W  idle cycles inserted between repetitions
- bit_out  output  1  serial data
- bit_valid  output  1  high while `bit_out` carries a pattern bit
- frame_sof  output  1  high on the first bit of each repetition
- busy  output  1  high in SEND and GAP
- done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- One clock, `clk`. Reset `rst` is asynchronous and active-high.
- Moore outputs: all outputs decode from registered state only; no combinational path from any input to any output.
- States:
  - IDLE, SEND, GAP, DONE.
  - Internal registers: pat_r (PAT_W), idx (clog2 PAT_W), rep_left (CNT_W), gap_r (CNT_W), gap_cnt (CNT_W).
- Reset (async, any time):
  - state=IDLE; bit_out=IDLE_BIT; bit_valid=0; frame_sof=0; busy=0; done=0.
  - All internal counters 0.
  - A transfer in progress is discarded.
- IDLE:
  - On an edge with start=1: latch pat_in into pat_r, latch gap_in into gap_r.
  - rep_left := (rep_in==0) ? 1 : rep_in; idx := PAT_W-1; go to SEND.
  - Latency: the first pattern bit appears on bit_out in the cycle immediately after the start edge.
- SEND:
  - bit_out = pat_r[idx]; bit_valid = 1; busy = 1; frame_sof = (idx==PAT_W-1).
  - Each edge with idx>0: idx decrements.
  - Edge with idx==0 and rep_left==1: go to DONE.
  - Edge with idx==0 and rep_left>1: rep_left decrements, idx := PAT_W-1. Then:
    - gap_r==0: stay in SEND; back-to-back, no idle bit.
    - gap_r>0: go to GAP with gap_cnt := gap_r.
- GAP:
  - bit_out = IDLE_BIT; bit_valid = 0; busy = 1.
  - gap_cnt decrements each edge.
  - Edge with gap_cnt==1: go to SEND. This gives exactly gap_r idle cycles.
- DONE:
  - done = 1, busy = 0, bit_valid = 0, bit_out = IDLE_BIT.
  - Unconditionally go to IDLE next edge.
  - start asserted in DONE is ignored.
- Frame length from the first bit to the last bit is R*PAT_W + (R-1)*G cycles, where R = effective repetitions and G = gap_r.
- start while busy or in DONE: ignored. No queuing.
- pat_in, rep_in and gap_in changing mid-transfer have no effect; only the latched copies are used.
- abort (synchronous) in SEND or GAP: go to IDLE next edge with no done pulse, and outputs return to idle values.
  - abort in IDLE or DONE: no effect; DONE still pulses.
  - abort and start both high in IDLE: abort wins, no transfer starts.
- rep_in at its maximum (2^CNT_W - 1) and gap_in at its maximum must work with no counter wrap-around.

Test Plan:
- Reset release, no start for 5 cycles -> bit_out=0, bit_valid=0, busy=0, done=0 throughout.
- pat_in=4'b1010, rep_in=1, gap_in=0, start pulsed at edge k:
  - cycles k+1..k+4: bit_out=1,0,1,0 with bit_valid=1 and frame_sof=1 only at k+1.
  - done=1 at k+5 only; busy=0 from k+5.
- pat_in=4'b1010, rep_in=3, gap_in=0 -> 12 consecutive valid bits 101010101010, frame_sof at offsets 0, 4 and 8, a single done pulse.
- pat_in=4'b1100, rep_in=2, gap_in=2 -> bits 1,1,0,0, then two cycles with bit_valid=0 and bit_out=0, then 1,1,0,0, then done. Total 10 cycles between start and done.
- Mid-transfer disturbances:
  - start re-pulsed during SEND, plus pat_in/rep_in changed mid-transfer -> output stream unchanged from the latched values.
  - abort asserted on the 3rd bit -> IDLE values next cycle, done never asserts.
  - a new start afterwards runs a full frame.
- Mid-transfer reset:
  - rst asserted asynchronously mid-GAP (between clock edges) -> all outputs go to reset values immediately.
  - after rst is released, rep_in=0 -> exactly one repetition sent.
